// File: rtl/tour_cmd_sched.sv
// Knight's-tour command scheduler: passes host commands through when idle, and
// during a tour splits each one-hot knight move into a vertical then a horizontal leg.
module tour_cmd_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        resp_send,
    output logic        tour_err
);

    localparam logic [4:0] LastIdx  = 5'd23;
    localparam logic [7:0] RespMove = 8'h5A;
    localparam logic [7:0] RespDone = 8'hA5;
    localparam logic [7:0] RespErr  = 8'hEE;

    typedef enum logic [2:0] {StIdle, StVIssue, StVWait, StHIssue, StHWait} state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  move_q, move_d;
    logic        err_q, err_d;
    logic [7:0]  resp_q, resp_d;
    logic        rsend_q, rsend_d;

    logic        move_ok;
    logic        dx_neg, dy_neg;
    logic [2:0]  dx_mag, dy_mag;
    logic [15:0] v_cmd, h_cmd;
    logic        idle;

    assign move_ok = (move_q != 8'd0) && ((move_q & (move_q - 8'd1)) == 8'd0);
    assign idle    = (state_q == StIdle);

    // Move bit -> (dx, dy) as sign/magnitude; +x east, +y north.
    always_comb begin
        {dx_neg, dx_mag, dy_neg, dy_mag} = 8'd0;
        case (move_q)
            8'h01:   {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b0, 3'd1, 1'b0, 3'd2};
            8'h02:   {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b1, 3'd1, 1'b0, 3'd2};
            8'h04:   {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b1, 3'd2, 1'b0, 3'd1};
            8'h08:   {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b1, 3'd2, 1'b1, 3'd1};
            8'h10:   {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b1, 3'd1, 1'b1, 3'd2};
            8'h20:   {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b0, 3'd1, 1'b1, 3'd2};
            8'h40:   {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b0, 3'd2, 1'b1, 3'd1};
            8'h80:   {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b0, 3'd2, 1'b0, 3'd1};
            default: {dx_neg, dx_mag, dy_neg, dy_mag} = 8'd0;
        endcase
        v_cmd = {4'h4, (dy_neg ? 8'h7F : 8'h00), 1'b0, dy_mag};
        h_cmd = {4'h5, (dx_neg ? 8'h3F : 8'hBF), 1'b0, dx_mag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 5'd0;
            move_q  <= 8'd0;
            err_q   <= 1'b0;
            resp_q  <= RespDone;
            rsend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            move_q  <= move_d;
            err_q   <= err_d;
            resp_q  <= resp_d;
            rsend_q <= rsend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        move_d  = move_q;
        err_d   = err_q;
        resp_d  = resp_q;
        rsend_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_tour) begin
                    idx_d   = 5'd0;
                    err_d   = 1'b0;
                    move_d  = move;
                    state_d = StVIssue;
                end
            end
            StVIssue: begin
                // A bad move aborts before any command is offered.
                if (!move_ok) begin
                    err_d   = 1'b1;
                    resp_d  = RespErr;
                    rsend_d = 1'b1;
                    state_d = StIdle;
                end else if (clr_cmd_rdy) begin
                    state_d = StVWait;
                end
            end
            StVWait: begin
                if (send_resp) state_d = StHIssue;
            end
            StHIssue: begin
                if (clr_cmd_rdy) state_d = StHWait;
            end
            StHWait: begin
                if (send_resp) begin
                    rsend_d = 1'b1;
                    if (idx_q == LastIdx) begin
                        resp_d  = RespDone;
                        state_d = StIdle;
                    end else begin
                        resp_d  = RespMove;
                        idx_d   = idx_q + 5'd1;
                        move_d  = move;
                        state_d = StVIssue;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        if (!idle) begin
            clr_cmd_rdy_UART = 1'b0;
            cmd_rdy          = (state_q == StHIssue) || ((state_q == StVIssue) && move_ok);
            cmd              = ((state_q == StVIssue) || (state_q == StVWait)) ? v_cmd : h_cmd;
        end
        // The registered strobe may land in the first idle cycle after a tour ends.
        resp_send = rsend_q | (idle & send_resp);
        resp      = rsend_q ? resp_q : RespDone;
    end

    assign mv_indx  = idx_q;
    assign tour_err = err_q;

endmodule
